relu_out_packer: RTL and testbench

Downstream neighbour of the `relu` stage. It takes the 8-lane fixed-point activation bus with its per-lane valids and compacts the valid lanes, in lane order, into dense `MEM_WIDTH`-bit words. It writes those words sequentially into the activation SRAM, starting at a programmed base address. It counts elements against a programmed frame length, zero-pads and flushes the last partial word, and pulses `done` when the frame is complete.

---
 rtl/relu_out_packer_if.sv | 35 +++
 rtl/relu_out_packer.sv | 176 +++++++++++++++++
 tb/tb_relu_out_packer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/relu_out_packer_if.sv
// rtl/relu_out_packer_if.sv - control, activation-bus and SRAM-write bundle for relu_out_packer
//   start / cfg_data_num / cfg_base_addr : frame kick-off and its configuration
//   in_fixed_data / in_fixed_data_vld    : 8-lane activation bus with per-lane valids
//   mem_wen / mem_waddr / mem_wdata      : sequential SRAM write port
//   busy / done                          : frame status
//   slave modport = packer side, master modport = driver side
interface relu_out_packer_if #(
  parameter int BUS_NUM          = 8,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int DATA_NUM_WIDTH   = 10,
  parameter int MEM_WIDTH        = BUS_NUM * FIXED_DATA_WIDTH,
  parameter int MEM_DEPTH        = 512,
  parameter int ADDR_WIDTH       = $clog2(MEM_DEPTH)
) ();
  logic                      start;
  logic [DATA_NUM_WIDTH-1:0] cfg_data_num;
  logic [ADDR_WIDTH-1:0]     cfg_base_addr;
  logic [MEM_WIDTH-1:0]      in_fixed_data;
  logic [BUS_NUM-1:0]        in_fixed_data_vld;
  logic                      mem_wen;
  logic [ADDR_WIDTH-1:0]     mem_waddr;
  logic [MEM_WIDTH-1:0]      mem_wdata;
  logic                      busy;
  logic                      done;

  modport slave (
    input  start, cfg_data_num, cfg_base_addr, in_fixed_data, in_fixed_data_vld,
    output mem_wen, mem_waddr, mem_wdata, busy, done
  );

  modport master (
    output start, cfg_data_num, cfg_base_addr, in_fixed_data, in_fixed_data_vld,
    input  mem_wen, mem_waddr, mem_wdata, busy, done
  );
endinterface

// File: rtl/relu_out_packer.sv
// rtl/relu_out_packer.sv - compacts valid activation lanes into dense SRAM words
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : relu_out_packer_if.slave (start/cfg in, lane bus in, SRAM write + busy/done out)
module relu_out_packer #(
  parameter int BUS_NUM          = 8,
  parameter int FIXED_DATA_WIDTH = 8,
  parameter int DATA_NUM_WIDTH   = 10,
  parameter int MEM_WIDTH        = BUS_NUM * FIXED_DATA_WIDTH,
  parameter int MEM_DEPTH        = 512,
  parameter int ADDR_WIDTH       = $clog2(MEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  relu_out_packer_if.slave   bus
);

  localparam int FILL_W = $clog2(BUS_NUM);
  localparam int CNT_W  = FILL_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef logic [BUS_NUM-1:0][FIXED_DATA_WIDTH-1:0]   lanes_t;
  typedef logic [2*BUS_NUM-1:0][FIXED_DATA_WIDTH-1:0] lanes2_t;

  logic [1:0]                state_q, state_d;
  logic [DATA_NUM_WIDTH-1:0] limit_q, limit_d;
  logic [DATA_NUM_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0]     ptr_q, ptr_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  lanes_t                    stage_q, stage_d;
  logic                      wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]     waddr_q, waddr_d;
  logic [MEM_WIDTH-1:0]      wdata_q, wdata_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  lanes_t                    in_lanes;
  lanes_t                    acc;
  lanes2_t                   merged;
  logic [CNT_W-1:0]          p;
  logic [CNT_W-1:0]          sum;
  logic [DATA_NUM_WIDTH-1:0] remaining;
  logic [ADDR_WIDTH-1:0]     ptr_next;

  assign in_lanes = bus.in_fixed_data;
  assign ptr_next = (ptr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  // Accept valid lanes in index order until the remaining quota is used up,
  // packing them densely into acc[0..p-1]; later lanes beyond quota drop.
  always_comb begin
    remaining = limit_q - count_q;
    acc       = '0;
    p         = '0;
    for (int i = 0; i < BUS_NUM; i++) begin
      if (bus.in_fixed_data_vld[i] && (DATA_NUM_WIDTH'(p) < remaining)) begin
        acc[p[FILL_W-1:0]] = in_lanes[i];
        p = p + 1'b1;
      end
    end
  end

  // Staging entries occupy merged[0..fill-1], accepted lanes follow them.
  // Unused entries stay zero, which gives the flush word its zero padding.
  always_comb begin
    merged = '0;
    for (int j = 0; j < BUS_NUM; j++) begin
      if (FILL_W'(j) < fill_q) begin
        merged[j] = stage_q[j];
      end
    end
    for (int i = 0; i < BUS_NUM; i++) begin
      merged[CNT_W'(fill_q) + CNT_W'(i)] = acc[i];
    end
    sum = CNT_W'(fill_q) + p;
  end

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    stage_d = stage_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          limit_d = bus.cfg_data_num;
          count_d = '0;
          fill_d  = '0;
          stage_d = '0;
          ptr_d   = bus.cfg_base_addr;
          state_d = (bus.cfg_data_num == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        count_d = count_q + DATA_NUM_WIDTH'(p);
        if (sum >= CNT_W'(BUS_NUM)) begin
          wen_d   = 1'b1;
          waddr_d = ptr_q;
          wdata_d = merged[BUS_NUM-1:0];
          ptr_d   = ptr_next;
          stage_d = merged[2*BUS_NUM-1:BUS_NUM];
          fill_d  = FILL_W'(sum - CNT_W'(BUS_NUM));
        end else begin
          stage_d = merged[BUS_NUM-1:0];
          fill_d  = sum[FILL_W-1:0];
        end
        if (count_d == limit_q) begin
          state_d = (fill_d == '0) ? S_DONE : S_FLUSH;
        end
      end
      S_FLUSH: begin
        wen_d   = 1'b1;
        waddr_d = ptr_q;
        wdata_d = stage_q;
        ptr_d   = ptr_next;
        stage_d = '0;
        fill_d  = '0;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
    // Leaving RUN/FLUSH raises done together with the final write. A
    // zero-length frame reaches DONE without having raised it, so DONE
    // emits it one cycle later instead.
    done_d = (((state_q == S_RUN) || (state_q == S_FLUSH)) && (state_d == S_DONE)) ||
             ((state_q == S_DONE) && !done_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      limit_q <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      fill_q  <= '0;
      stage_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      stage_q <= stage_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_wen   = wen_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_relu_out_packer.sv
// tb/tb_relu_out_packer.sv - randomized and directed bench for relu_out_packer
module tb_relu_out_packer;
  localparam int BN = 8;
  localparam int FW = 8;
  localparam int DW = 10;
  localparam int MW = 64;
  localparam int MD = 512;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  relu_out_packer_if #(.BUS_NUM(BN), .FIXED_DATA_WIDTH(FW), .DATA_NUM_WIDTH(DW),
                       .MEM_WIDTH(MW), .MEM_DEPTH(MD), .ADDR_WIDTH(AW)) bus ();

  relu_out_packer #(.BUS_NUM(BN), .FIXED_DATA_WIDTH(FW), .DATA_NUM_WIDTH(DW),
                    .MEM_WIDTH(MW), .MEM_DEPTH(MD), .ADDR_WIDTH(AW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] wr_a[$];
  logic [63:0] wr_d[$];
  int          wr_c[$];
  int          dn_c[$];

  always @(negedge clk) begin
    if (bus.mem_wen) begin
      wr_a.push_back(64'(bus.mem_waddr));
      wr_d.push_back(bus.mem_wdata);
      wr_c.push_back(cyc);
    end
    if (bus.done) dn_c.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [63:0] bq_d[$];
  logic [7:0]  bq_m[$];

  function automatic logic [63:0] seq_word(input int first);
    logic [63:0] w;
    for (int i = 0; i < BN; i++) w[i*8 +: 8] = 8'(first + i);
    return w;
  endfunction

  task automatic clear_mon();
    wr_a.delete(); wr_d.delete(); wr_c.delete(); dn_c.delete();
  endtask

  // Reference: the frame is the first num valid bytes in beat/lane order,
  // laid out 8 per word from base (mod depth), last word zero-padded.
  task automatic run_frame(input int base, input int num, input bit inj_start, input string name);
    logic [7:0]  acc[$];
    logic [63:0] d, w;
    logic [7:0]  m;
    int sc, fc, exp_done, nw, nchk;
    fc = -1;
    @(negedge clk);
    clear_mon();
    bus.start = 1'b1;
    bus.cfg_data_num = DW'(num);
    bus.cfg_base_addr = AW'(base);
    sc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, ":busy"}, 64'(bus.busy), 64'(num != 0));
    for (int b = 0; b < bq_d.size(); b++) begin
      d = bq_d[b];
      m = bq_m[b];
      bus.in_fixed_data = d;
      bus.in_fixed_data_vld = m;
      if (inj_start && b == 0) begin
        bus.start = 1'b1;
        bus.cfg_data_num = DW'(3);
        bus.cfg_base_addr = AW'(300);
      end
      for (int l = 0; l < BN; l++) begin
        if (m[l] && acc.size() < num) begin
          acc.push_back(d[l*8 +: 8]);
          if (acc.size() == num) fc = cyc;
        end
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.in_fixed_data_vld = '0;
    repeat (4) @(negedge clk);

    nw = (num + BN - 1) / BN;
    if (num == 0) exp_done = sc + 2;
    else if (num % BN == 0) exp_done = fc + 1;
    else exp_done = fc + 2;

    chk({name, ":nwr"}, 64'(wr_a.size()), 64'(nw));
    nchk = (wr_a.size() < nw) ? wr_a.size() : nw;
    for (int k = 0; k < nchk; k++) begin
      w = '0;
      for (int b = 0; b < BN; b++)
        if (k*BN + b < num) w[b*8 +: 8] = acc[k*BN + b];
      chk($sformatf("%s:addr%0d", name, k), wr_a[k], 64'((base + k) % MD));
      chk($sformatf("%s:data%0d", name, k), wr_d[k], w);
    end
    chk({name, ":ndone"}, 64'(dn_c.size()), 64'd1);
    if (dn_c.size() > 0) chk({name, ":done_cyc"}, 64'(dn_c[0]), 64'(exp_done));
    if (nw > 0 && wr_c.size() > 0)
      chk({name, ":last_wr_cyc"}, 64'(wr_c[wr_c.size()-1]), 64'(exp_done));
    bq_d.delete();
    bq_m.delete();
  endtask

  task automatic add_beat(input logic [7:0] m, input logic [63:0] d);
    bq_m.push_back(m);
    bq_d.push_back(d);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int num, base, got;
    logic [7:0] m;
    bus.start = 1'b0;
    bus.cfg_data_num = '0;
    bus.cfg_base_addr = '0;
    bus.in_fixed_data = '0;
    bus.in_fixed_data_vld = '0;
    repeat (3) @(negedge clk);
    chk("rst:wen", 64'(bus.mem_wen), 64'd0);
    chk("rst:waddr", 64'(bus.mem_waddr), 64'd0);
    chk("rst:wdata", bus.mem_wdata, 64'd0);
    chk("rst:busy", 64'(bus.busy), 64'd0);
    chk("rst:done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full beats, with a second start pulse injected during RUN
    add_beat(8'hFF, seq_word(0));
    add_beat(8'hFF, seq_word(8));
    run_frame(0, 16, 1'b1, "full");
    if (wr_d.size() >= 2) begin
      chk("full:gold0", wr_d[0], 64'h0706050403020100);
      chk("full:gold1", wr_d[1], 64'h0F0E0D0C0B0A0908);
    end

    // Partial masks, truncation, flush
    add_beat(8'h0F, 64'hEEEEEEEE_04030201);
    add_beat(8'hFF, seq_word(5));
    run_frame(4, 10, 1'b0, "trunc");
    if (wr_d.size() >= 2) begin
      chk("trunc:gold0", wr_d[0], 64'h0807060504030201);
      chk("trunc:gold1", wr_d[1], 64'h0000000000000A09);
    end

    // Sparse and idle beats
    add_beat(8'h81, seq_word(8'h10));
    add_beat(8'h00, seq_word(8'h10));
    add_beat(8'h3C, seq_word(8'h10));
    add_beat(8'h42, seq_word(8'h10));
    run_frame(20, 8, 1'b0, "sparse");
    if (wr_d.size() >= 1) chk("sparse:gold", wr_d[0], 64'h1611151413121710);

    // Address wrap
    add_beat(8'hFF, seq_word(8'h40));
    add_beat(8'hFF, seq_word(8'h48));
    run_frame(511, 16, 1'b0, "wrap");

    // Zero length
    run_frame(33, 0, 1'b0, "zero");

    // Reset mid-frame
    @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_data_num = DW'(20);
    bus.cfg_base_addr = AW'(7);
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_fixed_data = seq_word(8'h70);
    bus.in_fixed_data_vld = 8'h07;
    @(negedge clk);
    bus.in_fixed_data_vld = '0;
    clear_mon();
    rst_n = 1'b0;
    #1;
    chk("midrst:wen", 64'(bus.mem_wen), 64'd0);
    chk("midrst:waddr", 64'(bus.mem_waddr), 64'd0);
    chk("midrst:wdata", bus.mem_wdata, 64'd0);
    chk("midrst:busy", 64'(bus.busy), 64'd0);
    chk("midrst:done", 64'(bus.done), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst:nwr", 64'(wr_a.size()), 64'd0);
    chk("midrst:ndone", 64'(dn_c.size()), 64'd0);
    add_beat(8'hFF, seq_word(8'h20));
    add_beat(8'h1F, seq_word(8'h28));
    run_frame(100, 12, 1'b0, "after_rst");

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      num  = $urandom_range(1, 40);
      base = $urandom_range(0, MD - 1);
      got  = 0;
      while (got < num) begin
        m = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        add_beat(m, {$urandom, $urandom});
        got += $countones(m);
      end
      repeat (2) add_beat(8'($urandom), {$urandom, $urandom});
      run_frame(base, num, f[0], $sformatf("rnd%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
